ldb_extract: RTL and testbench

//  Byte-field extractor (LDB): reads a field out of a 32-bit word. It rotates the

---
 rtl/ldb_extract_pkg.sv | 21 ++
 rtl/ldb_extract_rot32.sv | 30 +++
 rtl/ldb_extract.sv | 126 ++++++++++++
 tb/tb_ldb_extract.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldb_extract_pkg.sv
// ---------------------------------------------------------------------------
// ldb_extract_pkg
//   Shared constants and types for the LDB byte-field extractor and any
//   other unit that reuses its rotator.
//   Contents:
//     LDB_WIDTH   datapath width in bits
//     LDB_POSW    width of a bit-position / field-length operand
//     ext_mode_e  how the bits above the extracted field are filled
// ---------------------------------------------------------------------------
package ldb_extract_pkg;

    localparam int LDB_WIDTH = 32;
    localparam int LDB_POSW  = $clog2(LDB_WIDTH);

    // Encoding of the in_sext request bit.
    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

endpackage

// File: rtl/ldb_extract_rot32.sv
// ---------------------------------------------------------------------------
// ldb_extract_rot32
//   Combinational right rotator. Bit i of the result is bit (i + amount) of
//   the source, modulo WIDTH. Shared with the deposit-side masker path.
//   Ports:
//     word     in   WIDTH  source word
//     amount   in   AMTW   rotate-right distance
//     rotated  out  WIDTH  rotated word
// ---------------------------------------------------------------------------
module ldb_extract_rot32
    import ldb_extract_pkg::*;
#(
    parameter  int WIDTH = LDB_WIDTH,
    localparam int AMTW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    input  logic [AMTW-1:0]  amount,
    output logic [WIDTH-1:0] rotated
);

    // The index sum is AMTW bits wide, so it wraps modulo WIDTH on its own;
    // this is only a true rotate because WIDTH is a power of two.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rotated[i] = word[AMTW'(i) + amount];
        end
    end

endmodule

// File: rtl/ldb_extract.sv
// ---------------------------------------------------------------------------
// ldb_extract
//   LDB byte-field extractor. Rotates the source word right by in_pos,
//   keeps the low in_len+1 bits and optionally sign-extends the field.
//   Two pipeline registers (rotate stage, mask stage) with valid/ready
//   handshakes on both sides and full throughput.
//   Ports:
//     clk        in   1      clock, rising edge
//     reset_n    in   1      asynchronous active-low reset
//     flush      in   1      synchronous pipeline clear
//     in_valid   in   1      request present
//     in_ready   out  1      request accepted when in_valid & in_ready
//     in_word    in   WIDTH  source word
//     in_pos     in   POSW   field LSB position
//     in_len     in   POSW   field width minus one
//     in_sext    in   1      1: sign-extend, 0: zero-extend
//     out_valid  out  1      result present
//     out_ready  in   1      result taken when out_valid & out_ready
//     out_field  out  WIDTH  right-justified field
// ---------------------------------------------------------------------------
module ldb_extract
    import ldb_extract_pkg::*;
#(
    parameter  int WIDTH = LDB_WIDTH,
    localparam int POSW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic [POSW-1:0]  in_pos,
    input  logic [POSW-1:0]  in_len,
    input  logic             in_sext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_field
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_rot_q,   s1_rot_d;
    logic [POSW-1:0]  s1_len_q,   s1_len_d;
    ext_mode_e        s1_sext_q,  s1_sext_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_field_q, s2_field_d;

    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] rot_word;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] field;

    ldb_extract_rot32 #(.WIDTH(WIDTH)) u_rot (
        .word    (in_word),
        .amount  (in_pos),
        .rotated (rot_word)
    );

    always_comb begin
        // Stage 2 can take new data when it is empty or its result is
        // leaving; stage 1 can accept when empty or when it drains into s2.
        // Flush blocks acceptance so the aborted cycle starts nothing new.
        s2_load  = !s2_valid_q || out_ready;
        in_ready = !flush && (!s1_valid_q || s2_load);
        accept   = in_valid && in_ready;

        // len = WIDTH-1 gives a zero shift (all ones), leaving no bits to fill.
        mask  = {WIDTH{1'b1}} >> (POSW'(WIDTH - 1) - s1_len_q);
        fill  = (s1_sext_q == EXT_SIGN && s1_rot_q[s1_len_q]) ? ~mask : '0;
        field = (s1_rot_q & mask) | fill;

        s1_valid_d = s1_valid_q;
        s1_rot_d   = s1_rot_q;
        s1_len_d   = s1_len_q;
        s1_sext_d  = s1_sext_q;
        s2_valid_d = s2_valid_q;
        s2_field_d = s2_field_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_rot_d   = rot_word;
                s1_len_d   = in_len;
                s1_sext_d  = ext_mode_e'(in_sext);
            end else if (s2_load) begin
                s1_valid_d = 1'b0;
            end

            // The field register only changes when a real result arrives so
            // a stalled output never glitches.
            if (s2_load) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_field_d = field;
                end
            end
        end

        out_valid = s2_valid_q;
        out_field = s2_field_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_rot_q   <= '0;
            s1_len_q   <= '0;
            s1_sext_q  <= EXT_ZERO;
            s2_valid_q <= 1'b0;
            s2_field_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rot_q   <= s1_rot_d;
            s1_len_q   <= s1_len_d;
            s1_sext_q  <= s1_sext_d;
            s2_valid_q <= s2_valid_d;
            s2_field_q <= s2_field_d;
        end
    end

endmodule

// File: tb/tb_ldb_extract.sv
// ---------------------------------------------------------------------------
// tb_ldb_extract
//   Self-checking bench for ldb_extract: directed field cases, wrap-around,
//   backpressure, flush, asynchronous reset and a randomized stream against
//   a bit-by-bit field model.
// ---------------------------------------------------------------------------
module tb_ldb_extract;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [4:0]  in_pos;
    logic [4:0]  in_len;
    logic        in_sext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_field;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ldb_extract dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_pos    (in_pos),
        .in_len    (in_len),
        .in_sext   (in_sext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field)
    );

    // Field bit k is source bit (pos+k) mod 32; above the field, copy the
    // field MSB when sign-extending.
    function automatic logic [31:0] ref_extract(input logic [31:0] word, input int pos,
                                                input int len, input bit sext);
        logic [31:0] f;
        f = '0;
        for (int k = 0; k <= len; k++) f[k] = word[(pos + k) % 32];
        if (sext && f[len]) begin
            for (int k = len + 1; k < 32; k++) f[k] = 1'b1;
        end
        return f;
    endfunction

    task automatic drive_req(input logic [31:0] w, input int pos, input int len, input bit s);
        in_valid = 1'b1;
        in_word  = w;
        in_pos   = 5'(pos);
        in_len   = 5'(len);
        in_sext  = s;
    endtask

    // Sends one request with out_ready held high and returns the result and
    // the number of falling edges after the accepting edge until out_valid.
    task automatic issue(input logic [31:0] w, input int pos, input int len, input bit s,
                         output logic [31:0] got, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        got = '0;
        @(negedge clk);
        drive_req(w, pos, len, s);
        out_ready = 1'b1;
        #1;
        for (int t = 0; t < 20 && !in_ready; t++) begin
            @(negedge clk);
            #1;
        end
        if (!in_ready) return;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (out_valid) begin
                got = out_field;
                ok  = 1'b1;
                return;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // Loads both stages with out_ready low; leaves the bench just after the
    // second accepting edge. ok reports whether both were accepted in time.
    task automatic fill_two(output bit ok);
        int acc;
        acc = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 10 && acc < 2; t++) begin
            @(negedge clk);
            drive_req($urandom, $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom));
            #1;
            if (in_ready) acc++;
            @(posedge clk);
        end
        ok = (acc == 2);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_pos    = '0;
        in_len    = '0;
        in_sext   = 1'b0;
        out_ready = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_field !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: out_valid=%b out_field=%h, required 0 / 00000000", out_valid, out_field);
        end
        #20;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] w[5]   = '{32'h12345678, 32'h0000F000, 32'h0000F000, 32'h80000001, 32'h80000001};
        int          p[5]   = '{8, 12, 12, 31, 0};
        int          l[5]   = '{7, 3, 3, 1, 31};
        bit          s[5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp[5] = '{32'h00000056, 32'hFFFFFFFF, 32'h0000000F, 32'h00000003, 32'h80000001};
        logic [31:0] got;
        int          lat;
        bit          ok;
        for (int i = 0; i < 5; i++) begin
            issue(w[i], p[i], l[i], s[i], got, lat, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL directed_%0d_timeout: no result, required one", i);
            end else begin
                checks++;
                if (got !== exp[i]) begin
                    failures++;
                    $display("[TB] FAIL directed_%0d_field: got %h, required %h", i, got, exp[i]);
                end
                checks++;
                if (lat != 2) begin
                    failures++;
                    $display("[TB] FAIL directed_%0d_latency: got %0d, required 2", i, lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[4];
        int          p[4];
        int          l[4];
        bit          s[4];
        logic [31:0] exp[4];
        int          sent;
        int          got;
        for (int i = 0; i < 4; i++) begin
            w[i]   = $urandom;
            p[i]   = $urandom_range(0, 31);
            l[i]   = $urandom_range(0, 31);
            s[i]   = 1'($urandom);
            exp[i] = ref_extract(w[i], p[i], l[i], s[i]);
        end
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            if (sent < 4) drive_req(w[sent], p[sent], l[sent], s[sent]);
            else          in_valid = 1'b0;
            #1;
            if (c == 4) begin
                checks++;
                if (sent != 2 || in_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL bp_stall: accepted=%0d in_ready=%b, required 2 / 0", sent, in_ready);
                end
                checks++;
                if (out_valid !== 1'b1 || out_field !== exp[0]) begin
                    failures++;
                    $display("[TB] FAIL bp_hold: out_valid=%b out_field=%h, required 1 / %h", out_valid, out_field, exp[0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_field !== exp[got]) begin
                    failures++;
                    $display("[TB] FAIL bp_result_%0d: got %h, required %h", got, out_field, exp[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        checks++;
        if (got != 4) begin
            failures++;
            $display("[TB] FAIL bp_count: delivered %0d, required 4", got);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_no_dup: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        bit ok;
        fill_two(ok);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b0;
        drive_req(32'hDEADBEEF, 4, 7, 1'b0);
        #1;
        checks++;
        if (!ok || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_prefill: filled=%b out_valid=%b, required 1 / 1", ok, out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_in_ready: in_ready=%b, required 0", in_ready);
        end
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_out_valid: out_valid=%b, required 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_empty: out_valid=%b in_ready=%b, required 0 / 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        bit          ok;
        logic [31:0] got;
        int          lat;
        fill_two(ok);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (!ok || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL areset_prefill: filled=%b out_valid=%b, required 1 / 1", ok, out_valid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_field !== 32'h0) begin
            failures++;
            $display("[TB] FAIL areset_clear: out_valid=%b out_field=%h, required 0 / 00000000", out_valid, out_field);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL areset_no_pulse: out_valid=%b, required 0", out_valid);
        end
        issue(32'hCAFE1234, 16, 15, 1'b1, got, lat, ok);
        checks++;
        if (!ok || got !== 32'hFFFFCAFE) begin
            failures++;
            $display("[TB] FAIL areset_resume: ok=%b got %h, required 1 / ffffcafe", ok, got);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] held;
        bit          hold_pending;
        logic [31:0] w;
        int          p;
        int          l;
        bit          s;
        hold_pending = 1'b0;
        held         = '0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c < 400) begin
                w = $urandom;
                p = $urandom_range(0, 31);
                l = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 31);
                s = 1'($urandom);
                drive_req(w, p, l, s);
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (hold_pending) begin
                checks++;
                if (out_valid !== 1'b1 || out_field !== held) begin
                    failures++;
                    $display("[TB] FAIL rand_stable_c%0d: out_valid=%b out_field=%h, required 1 / %h", c, out_valid, out_field, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand_extra_c%0d: got %h, required no result", c, out_field);
                end else begin
                    if (out_field !== exp_q[0]) begin
                        failures++;
                        $display("[TB] FAIL rand_field_c%0d: got %h, required %h", c, out_field, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            hold_pending = out_valid && !out_ready;
            held         = out_field;
            if (in_valid && in_ready) exp_q.push_back(ref_extract(w, p, l, s));
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL rand_drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
